// File: rtl/immediate_extend_stream.sv
`default_nettype none
// ============================================================================
// Module      : immediate_extend_stream
// Description : Decodes RISC-V immediates (I/S/B/U/J/Z) from a raw
//               instruction word and streams {imm, illegal} through a small
//               valid/ready output FIFO. Illegal types are counted in a
//               saturating 16-bit error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module immediate_extend_stream #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [2:0]               in_type_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_imm_o,
    output logic                     out_illegal_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              err_count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_TYPE_I = 3'd0;
    localparam logic [2:0] c_TYPE_S = 3'd1;
    localparam logic [2:0] c_TYPE_B = 3'd2;
    localparam logic [2:0] c_TYPE_U = 3'd3;
    localparam logic [2:0] c_TYPE_J = 3'd4;
    localparam logic [2:0] c_TYPE_Z = 3'd5;

    // Elaboration-time rejection of unsupported parameter values
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("immediate_extend_stream: XLEN must be 32 or 64");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("immediate_extend_stream: DEPTH must be a power of two >= 2");
    end

    logic [31:0]        w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_err_count;
    logic [XLEN-1:0]    r_mem_imm [DEPTH];
    logic               r_mem_ill [DEPTH];

    // Immediate decode ahead of the FIFO write; every legal format is built
    // as a 32-bit sign-correct value (Z has bit 31 clear) and then widened
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (in_type_i)
            c_TYPE_I: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            c_TYPE_S: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            c_TYPE_B: w_imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                                 in_instr_i[30:25], in_instr_i[11:8], 1'b0};
            c_TYPE_U: w_imm32 = {in_instr_i[31:12], 12'b0};
            c_TYPE_J: w_imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                                 in_instr_i[20], in_instr_i[30:21], 1'b0};
            c_TYPE_Z: w_imm32 = {27'b0, in_instr_i[19:15]};
            default:  w_illegal = 1'b1;
        endcase
        w_imm = XLEN'($signed(w_imm32));
    end

    // Handshake qualifiers derived from registered occupancy only
    always_comb begin
        w_in_ready  = (r_count < c_FULL);
        w_out_valid = (r_count != '0);
        w_push      = in_valid_i && w_in_ready;
        w_pop       = w_out_valid && out_ready_i;
    end

    // Pointer, occupancy and saturating error-counter state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_illegal && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // FIFO storage; contents are masked by occupancy so no reset is needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_imm[r_wr_ptr] <= w_imm;
            r_mem_ill[r_wr_ptr] <= w_illegal;
        end
    end

    // Output drive; head data forced to zero whenever the FIFO is empty
    always_comb begin
        in_ready_o    = w_in_ready;
        out_valid_o   = w_out_valid;
        out_imm_o     = w_out_valid ? r_mem_imm[r_rd_ptr] : '0;
        out_illegal_o = w_out_valid ? r_mem_ill[r_rd_ptr] : 1'b0;
        count_o       = r_count;
        err_count_o   = r_err_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_immediate_extend_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_immediate_extend_stream
// Description : Self-checking bench for immediate_extend_stream with a
//               32-bit/2-deep and a 64-bit/4-deep instance against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_immediate_extend_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 32-bit / depth-2 instance
    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_instr = '0;
    logic [2:0]  a_type = '0;
    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm;
    logic [1:0]  a_count;
    logic [15:0] a_err;

    // 64-bit / depth-4 instance
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_instr = '0;
    logic [2:0]  b_type = '0;
    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm;
    logic [2:0]  b_count;
    logic [15:0] b_err;

    int tests = 0;
    int fails = 0;

    logic [64:0] qa[$];
    logic [64:0] qb[$];
    int ea = 0;
    int eb = 0;

    immediate_extend_stream #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_instr_i(a_instr), .in_type_i(a_type),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_imm_o(a_imm), .out_illegal_o(a_illegal),
        .count_o(a_count), .err_count_o(a_err)
    );

    immediate_extend_stream #(.XLEN(64), .DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_instr_i(b_instr), .in_type_i(b_type),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_imm_o(b_imm), .out_illegal_o(b_illegal),
        .count_o(b_count), .err_count_o(b_err)
    );

    always #5 clk = ~clk;

    // Sign-extend the low n bits of x
    function automatic longint sext(longint x, int n);
        longint m;
        m = x & ((longint'(1) << n) - 1);
        if (((m >> (n - 1)) & 1) != 0) m = m - (longint'(1) << n);
        return m;
    endfunction

    // Reference decode: returns {illegal, imm64}
    function automatic logic [64:0] ref_entry(logic [31:0] ins, logic [2:0] t, int xlen);
        longint u;
        longint v;
        logic   ill;
        u   = longint'({32'b0, ins});
        v   = 0;
        ill = 1'b0;
        case (t)
            3'd0: v = sext(u >> 20, 12);
            3'd1: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            3'd2: v = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                           (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            3'd3: v = sext(u & 64'hFFFF_F000, 32);
            3'd4: v = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                           (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            3'd5: v = (u >> 15) & 31;
            default: begin v = 0; ill = 1'b1; end
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return {ill, v[63:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the reference model advanced alongside
    task automatic cyc();
        logic acc_a, pop_a, acc_b, pop_b;
        logic [64:0] ent_a, ent_b;
        acc_a = a_in_valid && (qa.size() < 2);
        pop_a = a_out_ready && (qa.size() > 0);
        acc_b = b_in_valid && (qb.size() < 4);
        pop_b = b_out_ready && (qb.size() > 0);
        ent_a = ref_entry(a_instr, a_type, 32);
        ent_b = ref_entry(b_instr, b_type, 64);
        @(posedge clk);
        #1;
        if (pop_a) void'(qa.pop_front());
        if (acc_a) begin
            qa.push_back(ent_a);
            if (ent_a[64] && ea < 16'hFFFF) ea++;
        end
        if (pop_b) void'(qb.pop_front());
        if (acc_b) begin
            qb.push_back(ent_b);
            if (ent_b[64] && eb < 16'hFFFF) eb++;
        end
    endtask

    task automatic check_a();
        chk("a_count", 64'(a_count), 64'(qa.size()));
        chk("a_valid", 64'(a_out_valid), 64'(qa.size() != 0));
        chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
        chk("a_imm", 64'(a_imm), (qa.size() != 0) ? qa[0][63:0] : 64'd0);
        chk("a_illegal", 64'(a_illegal), (qa.size() != 0) ? 64'(qa[0][64]) : 64'd0);
        chk("a_err", 64'(a_err), 64'(ea));
    endtask

    task automatic check_b();
        chk("b_count", 64'(b_count), 64'(qb.size()));
        chk("b_valid", 64'(b_out_valid), 64'(qb.size() != 0));
        chk("b_in_ready", 64'(b_in_ready), 64'(qb.size() < 4));
        chk("b_imm", b_imm, (qb.size() != 0) ? qb[0][63:0] : 64'd0);
        chk("b_illegal", 64'(b_illegal), (qb.size() != 0) ? 64'(qb[0][64]) : 64'd0);
        chk("b_err", 64'(b_err), 64'(eb));
    endtask

    logic [31:0] d_instr [6] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                                 32'h123450B7, 32'h004000EF, 32'h000FD073};
    logic [31:0] d_exp   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                 32'h12345000, 32'h00000004, 32'h0000001F};

    initial begin
        // Reset state
        #2;
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_imm", 64'(a_imm), 64'd0);
        chk("rst_illegal", 64'(a_illegal), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed formats, one-cycle latency, streaming with out_ready high
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'b1;
            a_instr    = d_instr[i];
            a_type     = 3'(i);
            cyc();
            chk($sformatf("fmt%0d_imm", i), 64'(a_imm), 64'(d_exp[i]));
            chk($sformatf("fmt%0d_cnt", i), 64'(a_count), 64'd1);
        end
        a_in_valid = 1'b0;
        cyc();
        chk("drain_valid", 64'(a_out_valid), 64'd0);

        // Backpressure: fill, ignored third push, then drain in order
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_instr = 32'hFFF00093; a_type = 3'd0; cyc();
        a_instr = 32'h123450B7; a_type = 3'd3; cyc();
        chk("bp_count", 64'(a_count), 64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        a_instr = 32'hFE20AE23; a_type = 3'd1; cyc();
        chk("bp_third_count", 64'(a_count), 64'd2);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("bp_head0", 64'(a_imm), 64'hFFFFFFFF);
        cyc();
        chk("bp_head1", 64'(a_imm), 64'h12345000);
        cyc();
        chk("bp_empty", 64'(a_out_valid), 64'd0);
        check_a();

        // Illegal type and error-counter saturation
        a_in_valid = 1'b1;
        a_type     = 3'd7;
        a_instr    = $urandom;
        cyc();
        chk("ill_imm", 64'(a_imm), 64'd0);
        chk("ill_flag", 64'(a_illegal), 64'd1);
        chk("ill_err1", 64'(a_err), 64'd1);
        for (int i = 0; i < 65533; i++) begin
            a_type  = 3'(6 + (i & 1));
            a_instr = $urandom;
            cyc();
        end
        chk("ill_errFFFE", 64'(a_err), 64'hFFFE);
        cyc();
        chk("ill_errFFFF", 64'(a_err), 64'hFFFF);
        cyc();
        chk("ill_err_sat", 64'(a_err), 64'hFFFF);
        a_in_valid = 1'b0;
        cyc();
        check_a();

        // Reset mid-flight: two queued entries discarded immediately
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_instr = 32'h123450B7; a_type = 3'd3; cyc();
        a_instr = 32'h004000EF; a_type = 3'd4; cyc();
        a_in_valid = 1'b0;
        chk("mid_pre_count", 64'(a_count), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_count", 64'(a_count), 64'd0);
        chk("mid_valid", 64'(a_out_valid), 64'd0);
        chk("mid_imm", 64'(a_imm), 64'd0);
        chk("mid_err", 64'(a_err), 64'd0);
        chk("mid_in_ready", 64'(a_in_ready), 64'd1);
        qa.delete(); qb.delete(); ea = 0; eb = 0;
        #1;
        rst = 1'b0;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_instr = 32'hFFF00093; a_type = 3'd0;
        cyc();
        chk("post_rst_imm", 64'(a_imm), 64'hFFFFFFFF);
        chk("post_rst_count", 64'(a_count), 64'd1);
        a_in_valid = 1'b0;
        cyc();
        chk("post_rst_empty", 64'(a_out_valid), 64'd0);

        // 64-bit instance: U sign extension
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_instr = 32'h800000B7; b_type = 3'd3;
        cyc();
        chk("b_u64", b_imm, 64'hFFFFFFFF80000000);
        b_in_valid = 1'b0;
        cyc();
        check_b();

        // 64-bit instance: simultaneous push/pop over 8 pointer wraps
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_instr = $urandom; b_type = 3'($urandom_range(0, 7)); cyc();
        end
        b_out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            b_instr = $urandom;
            b_type  = 3'($urandom_range(0, 7));
            cyc();
            chk("wrap_count", 64'(b_count), 64'd2);
            check_b();
        end
        b_in_valid = 1'b0;
        repeat (3) cyc();
        check_b();

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom);
            a_out_ready = 1'($urandom);
            a_instr     = $urandom;
            a_type      = 3'($urandom_range(0, 7));
            b_in_valid  = 1'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_instr     = $urandom;
            b_type      = 3'($urandom_range(0, 7));
            cyc();
            check_a();
            check_b();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/immediate_extend_stream.md
IMMEDIATE_EXTEND_STREAM -- requirements
Module: immediate_extend_stream

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL accept only 32 or 64.
REQ-002 Parameter DEPTH, default 2, output FIFO entries; SHALL accept only powers of two, at least 2.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 in_valid_i  input  1  request valid.
REQ-006 in_ready_o  output  1  block can accept a request.
REQ-007 in_instr_i  input  32  raw instruction word.
REQ-008 in_type_i  input  3  immediate type: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6-7 illegal.
REQ-009 out_valid_o  output  1  FIFO head valid.
REQ-010 out_ready_i  input  1  consumer accepts the head.
REQ-011 out_imm_o  output  XLEN  extended immediate at the FIFO head.
REQ-012 out_illegal_o  output  1  head entry came from an illegal type.
REQ-013 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 err_count_o  output  16  number of illegal requests accepted.

Function
REQ-015 Accept: in_valid_i and in_ready_o high on the same edge; entry written at that edge.
REQ-016 Drain: out_valid_o and out_ready_i high on the same edge; head popped at that edge.
REQ-017 in_ready_o SHALL equal (count_o < DEPTH); it is combinational from registered state only, with no combinational path from out_ready_i.
REQ-018 out_valid_o SHALL equal (count_o != 0).
REQ-019 Latency: an entry accepted at edge N into an empty FIFO SHALL appear on the outputs after edge N, i.e. one cycle.
REQ-020 Order: entries SHALL drain strictly in acceptance order (FIFO).
REQ-021 Simultaneous push and pop (not full) SHALL leave count_o unchanged and keep the data correct.
REQ-022 Full: no push; in_instr_i and in_type_i are ignored.
REQ-023 Empty with out_ready_i high: no pop; count_o SHALL stay 0 and not underflow.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 I: sign-extend instr[31:20].
REQ-026 S: sign-extend {instr[31:25], instr[11:7]}.
REQ-027 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-028 U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-029 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-030 Z: zero-extend instr[19:15].
REQ-031 Illegal type (6, 7): stored imm = 0 and illegal = 1; err_count_o increments on the accept edge and saturates at 0xFFFF.
REQ-032 Decode SHALL happen before the FIFO write; the FIFO stores {imm, illegal}.

Reset
REQ-033 rst_i high SHALL immediately clear count_o, both pointers, err_count_o, out_valid_o, out_illegal_o and out_imm_o (to 0), independent of clk_i.
REQ-034 After reset, in_ready_o = 1.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries; no entry accepted before reset appears afterwards.
REQ-036 The first edge after rst_i deasserts SHALL be able to accept a request.

Verification (XLEN=32, DEPTH=2 unless stated)
REQ-037 I, S, B, with out_ready_i=1:
- type 0, instr 0xFFF00093 -> out_imm_o = 0xFFFFFFFF one cycle later.
- type 1, instr 0xFE20AE23 -> out_imm_o = 0xFFFFFFFC.
- type 2, instr 0xFE000CE3 -> out_imm_o = 0xFFFFFFF8.
REQ-038 U, J, Z:
- type 3, instr 0x123450B7 -> out_imm_o = 0x12345000.
- type 4, instr 0x004000EF -> out_imm_o = 0x00000004.
- type 5, instr 0x000FD073 -> out_imm_o = 0x0000001F.
REQ-039 Backpressure:
- out_ready_i=0, push I 0xFFF00093 then U 0x123450B7 -> count_o = 2, in_ready_o = 0; a third push is ignored.
- then out_ready_i=1 -> outputs 0xFFFFFFFF, then 0x12345000, then out_valid_o = 0.
REQ-040 Illegal: type 7, any instr -> out_imm_o = 0, out_illegal_o = 1, err_count_o = 1.
- 65536 illegal pushes -> err_count_o = 0xFFFF.
REQ-041 Reset mid-flight: two entries queued, rst_i pulsed between edges -> count_o = 0 and out_valid_o = 0 immediately; no stale entries after release.
REQ-042 XLEN=64, DEPTH=4:
- type 3, instr 0x800000B7 -> 0xFFFFFFFF80000000.
- interleaved simultaneous push/pop over 8 wraps -> order preserved, count_o constant.
